periferico_receptor: RTL and testbench
======================================

PERIFERICO_RECEPTOR -- requirements
Module: periferico_receptor

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of the transferred data word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, receive buffer entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port send, input, 1 bit: request from the processor; asynchronous to clk.
REQ-006 SHALL have port dado, input, DATA_W bits: word from the processor; stable while send=1.
REQ-007 SHALL have port ack, output, 1 bit: handshake acknowledge to the processor; registered.
REQ-008 SHALL have port rd_en, input, 1 bit: local consumer pops the FIFO head.
REQ-009 SHALL have port dout, output, DATA_W bits: FIFO head word; valid when empty=0.
REQ-010 SHALL have port empty, output, 1 bit: FIFO holds no word.
REQ-011 SHALL have port full, output, 1 bit: FIFO holds FIFO_DEPTH words.
REQ-012 SHALL have port level, output, clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-013 SHALL act as the responder of a 4-phase send/ack handshake: send rises, ack rises, send falls, ack falls.
REQ-014 SHALL derive send_s, the synchronized send, and drive the FSM only from send_s.
REQ-015 SHALL implement FSM states IDLE, CAPTURE, ACK and no others.
REQ-016 IDLE -> CAPTURE when send_s=1 and full=0; otherwise remain in IDLE with ack=0.
REQ-017 CAPTURE SHALL write dado into the FIFO on its edge and SHALL always move to ACK after exactly one cycle.
REQ-018 ACK SHALL hold ack=1 and remain until send_s=0, then move to IDLE with ack=0.
REQ-019 ack SHALL be 1 exactly when the state is ACK.
REQ-020 A write SHALL occur once per handshake; holding send high SHALL NOT cause repeated writes.
REQ-021 When send_s=1 while full=1, the block SHALL withhold ack (backpressure) until a pop clears full, then proceed per REQ-016.
REQ-022 rd_en with empty=1 SHALL be ignored; level SHALL NOT underflow.
REQ-023 A simultaneous CAPTURE write and rd_en pop SHALL leave level unchanged and preserve word order.
REQ-024 The FIFO SHALL be first-in-first-out; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 dout SHALL present the head word combinationally from storage, with no extra read latency.

Reset
REQ-026 With rst=0 at a clock edge: state=IDLE, ack=0, level=0, empty=1, full=0, synchronizer flops=0.
REQ-027 Reset mid-handshake SHALL drop ack on that edge and discard the FIFO contents.
REQ-028 If send is still 1 after reset release, a new handshake SHALL start and capture dado again.

Configuration
REQ-029 Macro PERIFERICO_SYNC2_EN defined: send SHALL pass through two flops; ack rises 4 edges after the first edge sampling send=1 and falls 3 edges after the first edge sampling send=0.
REQ-030 Macro PERIFERICO_SYNC2_EN undefined: send SHALL pass through one flop; both latencies shrink by one edge (3 and 2).

Structure
REQ-031 Package periferico_pkg SHALL hold the FSM state enum and the default constants for DATA_W and FIFO_DEPTH.
REQ-032 The FIFO SHALL be a sub-module named periferico_fifo; the synchronizer and FSM SHALL stay in the top module.

Verification
REQ-033 Macro defined, send 0->1 with dado=16'hA5A5 -> ack=1 on the 4th edge; after send drops, ack=0 on the 3rd edge; dout=16'hA5A5, level=1.
REQ-034 Four handshakes with dado=1,2,3,4 and no reads -> full=1; a fifth send=1 gets no ack; one rd_en (dout=1) -> the fifth handshake completes, level=4.
REQ-035 Simultaneous rd_en and CAPTURE write at level=2 -> level stays 2, pop order intact.
REQ-036 rd_en pulses with empty=1 -> level=0, empty=1, no state change.
REQ-037 rst=0 while in ACK with level=3 -> next edge ack=0, level=0; send held at 1 through release -> new ack and level=1.
REQ-038 Macro undefined, repeat REQ-033 -> ack rises on the 3rd edge and falls on the 2nd edge.

Source files
------------

// File: rtl/periferico_pkg.sv
// Shared types and default sizing for the receptor peripheral.
package periferico_pkg;

   localparam int unsigned DATA_W_DEF     = 16;
   localparam int unsigned FIFO_DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_ACK     = 2'd2
   } state_e;

endpackage

// File: rtl/periferico_fifo.sv
// Receive FIFO: power-of-two depth, wrapping pointers, combinational head read.
module periferico_fifo
   import periferico_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_en,
   input  logic [DATA_W-1:0]           wr_data,
   input  logic                        rd_en,
   output logic [DATA_W-1:0]           dout,
   output logic                        empty,
   output logic                        full,
   output logic [$clog2(FIFO_DEPTH):0] level
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] LEVEL_FULL = (PTR_W+1)'(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]    level_q;
   logic              push, pop;

   assign empty = (level_q == '0);
   assign full  = (level_q == LEVEL_FULL);
   assign push  = wr_en && !full;
   assign pop   = rd_en && !empty;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         // Simultaneous push and pop leaves occupancy unchanged.
         case ({push, pop})
            2'b10:   level_q <= level_q + (PTR_W+1)'(1);
            2'b01:   level_q <= level_q - (PTR_W+1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign level = level_q;

endmodule

// File: rtl/periferico_receptor.sv
// Receptor peripheral: 4-phase send/ack responder writing each word into a FIFO.
// PERIFERICO_SYNC2_EN selects a two-flop send synchronizer; one flop otherwise.
module periferico_receptor
   import periferico_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        send,
   input  logic [DATA_W-1:0]           dado,
   output logic                        ack,
   input  logic                        rd_en,
   output logic [DATA_W-1:0]           dout,
   output logic                        empty,
   output logic                        full,
   output logic [$clog2(FIFO_DEPTH):0] level
);

   state_e state_q, state_d;
   logic   ack_q, ack_d;
   logic   send_s;
   logic   wr_en;

`ifdef PERIFERICO_SYNC2_EN
   logic sync1_q, sync2_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= send;
         sync2_q <= sync1_q;
      end
   end

   assign send_s = sync2_q;
`else
   logic sync1_q;

   always_ff @(posedge clk) begin
      if (!rst) sync1_q <= 1'b0;
      else      sync1_q <= send;
   end

   assign send_s = sync1_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
      end
   end

   // ack is registered from the next state so it is high exactly in ACK.
   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      case (state_q)
         ST_IDLE:    if (send_s && !full) state_d = ST_CAPTURE;
         ST_CAPTURE: begin
            wr_en   = 1'b1;
            state_d = ST_ACK;
         end
         ST_ACK:     if (!send_s) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
      ack_d = (state_d == ST_ACK);
   end

   assign ack = ack_q;

   periferico_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (dado),
      .rd_en   (rd_en),
      .dout    (dout),
      .empty   (empty),
      .full    (full),
      .level   (level)
   );

endmodule

// File: tb/tb_periferico_receptor.sv
// Directed, table-driven bench for periferico_receptor (DATA_W=16, FIFO_DEPTH=4).
module tb_periferico_receptor;

`ifdef PERIFERICO_SYNC2_EN
   localparam int unsigned RISE = 4;
   localparam int unsigned FALL = 3;
`else
   localparam int unsigned RISE = 3;
   localparam int unsigned FALL = 2;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        send;
   logic [15:0] dado;
   logic        ack;
   logic        rd_en;
   logic [15:0] dout;
   logic        empty;
   logic        full;
   logic [2:0]  level;

   int checks = 0;
   int errors = 0;

   typedef enum logic [1:0] {OP_HS, OP_POP} op_e;

   typedef struct {
      op_e         op;
      logic [15:0] data;
      logic        chk_head;
      logic [15:0] exp_head;
      logic [2:0]  exp_level;
      logic        exp_empty;
      logic        exp_full;
   } vec_t;

   vec_t vecs [12];

   periferico_receptor #(
      .DATA_W     (16),
      .FIFO_DEPTH (4)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .send  (send),
      .dado  (dado),
      .ack   (ack),
      .rd_en (rd_en),
      .dout  (dout),
      .empty (empty),
      .full  (full),
      .level (level)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic wait_ack(input logic val, input string name);
      for (int i = 0; i < 20 && ack !== val; i++) tick();
      chk(name, {31'd0, ack}, {31'd0, val});
   endtask

   task automatic handshake(input logic [15:0] data);
      send = 1'b1;
      dado = data;
      wait_ack(1'b1, "hs_ack_rise");
      send = 1'b0;
      wait_ack(1'b0, "hs_ack_fall");
   endtask

   task automatic pop();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         if (vecs[i].chk_head && vecs[i].op == OP_POP)
            chk($sformatf("v%0d_head", i), {16'd0, dout}, {16'd0, vecs[i].exp_head});
         if (vecs[i].op == OP_HS) handshake(vecs[i].data);
         else                      pop();
         if (vecs[i].chk_head && vecs[i].op == OP_HS)
            chk($sformatf("v%0d_head", i), {16'd0, dout}, {16'd0, vecs[i].exp_head});
         chk($sformatf("v%0d_level", i), {29'd0, level}, {29'd0, vecs[i].exp_level});
         chk($sformatf("v%0d_empty", i), {31'd0, empty}, {31'd0, vecs[i].exp_empty});
         chk($sformatf("v%0d_full", i),  {31'd0, full},  {31'd0, vecs[i].exp_full});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //               op      data   chk   head   lvl  emp  full
      vecs[0]  = '{OP_HS,  16'd1, 1'b1, 16'd1, 3'd1, 1'b0, 1'b0};
      vecs[1]  = '{OP_HS,  16'd2, 1'b1, 16'd1, 3'd2, 1'b0, 1'b0};
      vecs[2]  = '{OP_HS,  16'd3, 1'b1, 16'd1, 3'd3, 1'b0, 1'b0};
      vecs[3]  = '{OP_HS,  16'd4, 1'b1, 16'd1, 3'd4, 1'b0, 1'b1};
      vecs[4]  = '{OP_POP, 16'd0, 1'b1, 16'd2, 3'd3, 1'b0, 1'b0};
      vecs[5]  = '{OP_POP, 16'd0, 1'b1, 16'd3, 3'd2, 1'b0, 1'b0};
      vecs[6]  = '{OP_POP, 16'd0, 1'b1, 16'd5, 3'd1, 1'b0, 1'b0};
      vecs[7]  = '{OP_POP, 16'd0, 1'b1, 16'd6, 3'd0, 1'b1, 1'b0};
      vecs[8]  = '{OP_POP, 16'd0, 1'b0, 16'd0, 3'd0, 1'b1, 1'b0};
      vecs[9]  = '{OP_POP, 16'd0, 1'b0, 16'd0, 3'd0, 1'b1, 1'b0};
      vecs[10] = '{OP_HS,  16'd7, 1'b1, 16'd7, 3'd1, 1'b0, 1'b0};
      vecs[11] = '{OP_HS,  16'd8, 1'b1, 16'd7, 3'd2, 1'b0, 1'b0};

      rst = 1'b0; send = 1'b0; dado = '0; rd_en = 1'b0;
      tick(); tick();
      chk("rst_ack",   {31'd0, ack},   32'd0);
      chk("rst_level", {29'd0, level}, 32'd0);
      chk("rst_empty", {31'd0, empty}, 32'd1);
      chk("rst_full",  {31'd0, full},  32'd0);
      rst = 1'b1;
      tick();

      // Exact handshake latency with one word.
      send = 1'b1; dado = 16'hA5A5;
      for (int e = 1; e <= int'(RISE); e++) begin
         tick();
         chk($sformatf("lat_rise_e%0d", e), {31'd0, ack}, (e == int'(RISE)) ? 32'd1 : 32'd0);
      end
      send = 1'b0;
      for (int e = 1; e <= int'(FALL); e++) begin
         tick();
         chk($sformatf("lat_fall_e%0d", e), {31'd0, ack}, (e == int'(FALL)) ? 32'd0 : 32'd1);
      end
      chk("lat_dout",  {16'd0, dout},  32'h0000A5A5);
      chk("lat_level", {29'd0, level}, 32'd1);
      pop();
      chk("lat_pop_level", {29'd0, level}, 32'd0);

      // Fill to full, then backpressure.
      run_vecs(0, 3);
      send = 1'b1; dado = 16'd5;
      begin
         logic seen = 1'b0;
         for (int i = 0; i < 10; i++) begin
            tick();
            if (ack) seen = 1'b1;
         end
         chk("bp_no_ack", {31'd0, seen}, 32'd0);
      end
      chk("bp_level", {29'd0, level}, 32'd4);
      chk("bp_head",  {16'd0, dout},  32'd1);
      pop();
      wait_ack(1'b1, "bp_ack_after_pop");
      chk("bp_level_after", {29'd0, level}, 32'd4);
      chk("bp_full_after",  {31'd0, full},  32'd1);
      send = 1'b0;
      wait_ack(1'b0, "bp_ack_fall");
      run_vecs(4, 5);

      // Pop coinciding with the CAPTURE write at level 2 (contents 4,5).
      send = 1'b1; dado = 16'd6;
      for (int e = 1; e < int'(RISE); e++) tick();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("sim_ack",   {31'd0, ack},   32'd1);
      chk("sim_level", {29'd0, level}, 32'd2);
      chk("sim_head",  {16'd0, dout},  32'd5);
      send = 1'b0;
      wait_ack(1'b0, "sim_ack_fall");
      run_vecs(6, 9);
      chk("empty_pop_ack", {31'd0, ack}, 32'd0);

      // Reset while in ACK with three words held; send kept high through release.
      run_vecs(10, 11);
      send = 1'b1; dado = 16'd9;
      wait_ack(1'b1, "mid_ack_rise");
      chk("mid_level", {29'd0, level}, 32'd3);
      rst = 1'b0;
      tick();
      chk("mid_rst_ack",   {31'd0, ack},   32'd0);
      chk("mid_rst_level", {29'd0, level}, 32'd0);
      chk("mid_rst_empty", {31'd0, empty}, 32'd1);
      rst = 1'b1;
      tick();
      wait_ack(1'b1, "post_rst_ack");
      chk("post_rst_level", {29'd0, level}, 32'd1);
      chk("post_rst_dout",  {16'd0, dout},  32'd9);
      send = 1'b0;
      wait_ack(1'b0, "post_rst_fall");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
